// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback retire queue.
// The MEM->WB bus is a packed image of wb_entry_t, listed MSB first. With XLEN = 32 it is 199 bits.
package wb_pkg;

    localparam int WB_XLEN = 32;

    // Exception codes carried unchanged from MEM.
    localparam logic [5:0] ECODE_INT  = 6'h0;
    localparam logic [5:0] ECODE_ADEF = 6'h8;
    localparam logic [5:0] ECODE_ALE  = 6'h9;
    localparam logic [5:0] ECODE_SYS  = 6'hb;
    localparam logic [5:0] ECODE_BRK  = 6'hc;
    localparam logic [5:0] ECODE_INE  = 6'hd;

    // The exception entry vector is read through the CSR port while wb_ex is high.
    localparam logic [13:0] CSR_EENTRY = 14'hc;

    typedef struct packed {
        logic                 rf_we;
        logic [4:0]           rf_waddr;
        logic [WB_XLEN-1:0]   rf_wdata;
        logic [WB_XLEN-1:0]   pc;
        logic                 csr_re;
        logic                 csr_we;
        logic [13:0]          csr_num;
        logic [WB_XLEN-1:0]   csr_wmask;
        logic [WB_XLEN-1:0]   csr_wvalue;
        logic                 ertn;
        logic                 ex_en;
        logic [5:0]           ecode;
        logic [8:0]           esubcode;
        logic [WB_XLEN-1:0]   vaddr;
    } wb_entry_t;

    localparam int WB_BUS_W = $bits(wb_entry_t);

    // Bit offsets of each field inside mem_to_wb_bus. Each offset is the field's LSB.
    localparam int OFF_VADDR      = 0;
    localparam int OFF_ESUBCODE   = OFF_VADDR + WB_XLEN;
    localparam int OFF_ECODE      = OFF_ESUBCODE + 9;
    localparam int OFF_EX_EN      = OFF_ECODE + 6;
    localparam int OFF_ERTN       = OFF_EX_EN + 1;
    localparam int OFF_CSR_WVALUE = OFF_ERTN + 1;
    localparam int OFF_CSR_WMASK  = OFF_CSR_WVALUE + WB_XLEN;
    localparam int OFF_CSR_NUM    = OFF_CSR_WMASK + WB_XLEN;
    localparam int OFF_CSR_WE     = OFF_CSR_NUM + 14;
    localparam int OFF_CSR_RE     = OFF_CSR_WE + 1;
    localparam int OFF_PC         = OFF_CSR_RE + 1;
    localparam int OFF_RF_WDATA   = OFF_PC + WB_XLEN;
    localparam int OFF_RF_WADDR   = OFF_RF_WDATA + WB_XLEN;
    localparam int OFF_RF_WE      = OFF_RF_WADDR + 5;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } wb_state_t;

    // Reinterprets a raw MEM bus word as an entry.
    function automatic wb_entry_t unpack_bus(input logic [WB_BUS_W-1:0] bus);
        return wb_entry_t'(bus);
    endfunction

endpackage

// File: rtl/wb_retire_fifo.sv
// Storage for the in-order retire queue.
// The read and write pointers carry one extra wrap bit, so full and empty can be told apart.
// Entries are also presented in age order (index 0 = head) so that forwarding can scan them.
module wb_retire_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    push,
    input  wb_entry_t               push_data,
    input  logic                    pop,
    input  logic                    flush,
    output logic                    full,
    output logic                    empty,
    output wb_entry_t               head,
    output wb_entry_t [DEPTH-1:0]   ord_entry,
    output logic      [DEPTH-1:0]   ord_valid
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count;

    wb_entry_t mem_q [DEPTH];

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Pointer update. A flush empties the queue and drops the push made in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Pointer registers. Reset empties the queue immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage. With push and pop together at full, this write overwrites the head slot after it retires.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    // Age-ordered view. Slot k holds the k-th oldest entry and is valid while k < count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ord
        logic [AW-1:0] slot;
        assign slot          = rd_ptr_q[AW-1:0] + AW'(gi);
        assign ord_entry[gi] = mem_q[slot];
        assign ord_valid[gi] = (count > (AW+1)'(gi));
    end

    assign head = ord_entry[0];

endmodule

// File: rtl/wb_retire_queue.sv
// Writeback stage: an in-order retire queue between MEM and the regfile/CSR file.
// It retires one entry per cycle from the head and stalls the head on CSR access until csr_ready is high.
// When the head retires with an exception or ertn, it raises a flush pulse, empties the queue and spends one FLUSH cycle.
// It forwards the youngest queued result to ID.
// Optional feature: define WB_PERF_CNT_EN to add the perf_retired / perf_exc counters.
module wb_retire_queue
    import wb_pkg::*;
#(
    parameter int XLEN    = WB_XLEN,
    parameter int DEPTH   = 2,
    parameter int NUM_FWD = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    mem_to_wb_valid,
    input  logic [WB_BUS_W-1:0]     mem_to_wb_bus,
    output logic                    wb_allowin,
    input  logic                    csr_ready,
    output logic                    csr_re,
    output logic                    csr_we,
    output logic [13:0]             csr_num,
    output logic [XLEN-1:0]         csr_wmask,
    output logic [XLEN-1:0]         csr_wvalue,
    input  logic [XLEN-1:0]         csr_rvalue,
    output logic                    wb_ex,
    output logic [5:0]              wb_ecode,
    output logic [8:0]              wb_esubcode,
    output logic [XLEN-1:0]         wb_ex_pc,
    output logic [XLEN-1:0]         wb_vaddr,
    output logic                    ertn_flush,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [XLEN-1:0]         rf_wdata,
    input  logic [NUM_FWD*5-1:0]    fwd_raddr,
    output logic [NUM_FWD-1:0]      fwd_hit,
    output logic [NUM_FWD-1:0]      fwd_stall,
    output logic [NUM_FWD*XLEN-1:0] fwd_data,
    output logic [XLEN-1:0]         debug_wb_pc,
    output logic [3:0]              debug_wb_rf_we,
    output logic [4:0]              debug_wb_rf_wnum,
    output logic [XLEN-1:0]         debug_wb_rf_wdata
`ifdef WB_PERF_CNT_EN
    ,
    output logic [63:0]             perf_retired,
    output logic [31:0]             perf_exc
`endif
);

    wb_entry_t               head;
    wb_entry_t [DEPTH-1:0]   ord_entry;
    logic      [DEPTH-1:0]   ord_valid;
    logic                    q_full, q_empty, head_valid;
    wb_state_t               state_q, state_d;
    logic                    is_run, retire_go, flush_now, push_en;
    logic                    ex_go, ertn_go, rf_go;

    assign head_valid = ~q_empty;
    assign is_run     = (state_q == ST_RUN);
    // Only a CSR access waits for csr_ready. Every other head entry retires in the cycle it reaches the head.
    assign retire_go  = head_valid & (~(head.csr_re | head.csr_we) | csr_ready) & is_run;
    assign ex_go      = retire_go & head.ex_en;
    assign ertn_go    = retire_go & head.ertn & ~head.ex_en;
    assign rf_go      = retire_go & head.rf_we & ~head.ex_en & ~head.ertn;
    assign flush_now  = ex_go | ertn_go;
    // A full queue still accepts a push in a cycle where the head retires.
    assign wb_allowin = is_run & (~q_full | retire_go);
    assign push_en    = mem_to_wb_valid & wb_allowin;

    wb_retire_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push_en),
        .push_data (unpack_bus(mem_to_wb_bus)),
        .pop       (retire_go),
        .flush     (flush_now),
        .full      (q_full),
        .empty     (q_empty),
        .head      (head),
        .ord_entry (ord_entry),
        .ord_valid (ord_valid)
    );

    // Next state. A flushing retire costs one dead cycle, then the stage returns to RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush_now) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_RUN;
        else         state_q <= state_d;
    end

    // Head-driven CSR, exception, regfile and trace outputs. Every output is zero while the queue is empty.
    always_comb begin
        csr_re            = (head_valid & head.csr_re) | ex_go;
        csr_we            = head_valid & head.csr_we & ~head.ex_en & ~head.ertn;
        csr_num           = ex_go ? CSR_EENTRY : (head_valid ? head.csr_num : 14'd0);
        csr_wmask         = head_valid ? head.csr_wmask  : '0;
        csr_wvalue        = head_valid ? head.csr_wvalue : '0;
        wb_ex             = ex_go;
        ertn_flush        = ertn_go;
        wb_ecode          = head_valid ? head.ecode    : 6'd0;
        wb_esubcode       = head_valid ? head.esubcode : 9'd0;
        wb_ex_pc          = head_valid ? head.pc       : '0;
        wb_vaddr          = head_valid ? head.vaddr    : '0;
        rf_we             = rf_go;
        rf_waddr          = rf_go ? head.rf_waddr : 5'd0;
        rf_wdata          = rf_go ? (head.csr_re ? csr_rvalue : head.rf_wdata) : '0;
        debug_wb_pc       = retire_go ? head.pc : '0;
        debug_wb_rf_we    = {4{rf_go}};
        debug_wb_rf_wnum  = rf_waddr;
        debug_wb_rf_wdata = rf_wdata;
    end

    // Forwarding ports. The scan runs oldest to youngest, so the youngest matching entry wins.
    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_fwd
        logic [4:0]      raddr;
        logic            found, found_csr;
        logic [XLEN-1:0] found_data;

        assign raddr = fwd_raddr[gi*5 +: 5];

        // Find the youngest valid entry that writes raddr. Entries carrying an exception never produce data.
        always_comb begin
            found      = 1'b0;
            found_csr  = 1'b0;
            found_data = '0;
            for (int k = 0; k < DEPTH; k++) begin
                if (ord_valid[k] && ord_entry[k].rf_we && !ord_entry[k].ex_en &&
                    ord_entry[k].rf_waddr == raddr && raddr != 5'd0) begin
                    found      = 1'b1;
                    found_csr  = ord_entry[k].csr_re;
                    found_data = ord_entry[k].rf_wdata;
                end
            end
        end

        // A CSR read's value is only known at retire, so that match stalls ID instead of hitting.
        assign fwd_hit[gi]                 = found & ~found_csr;
        assign fwd_stall[gi]               = found & found_csr;
        assign fwd_data[gi*XLEN +: XLEN]   = (found & ~found_csr) ? found_data : '0;
    end

`ifdef WB_PERF_CNT_EN
    logic [63:0] perf_retired_q, perf_retired_d;
    logic [31:0] perf_exc_q, perf_exc_d;

    // The retire count covers every non-exception retire, ertn included. Both counters wrap silently.
    always_comb begin
        perf_retired_d = perf_retired_q + {63'd0, retire_go & ~head.ex_en};
        perf_exc_d     = perf_exc_q + {31'd0, ex_go};
    end

    // Counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_retired_q <= '0;
            perf_exc_q     <= '0;
        end else begin
            perf_retired_q <= perf_retired_d;
            perf_exc_q     <= perf_exc_d;
        end
    end

    assign perf_retired = perf_retired_q;
    assign perf_exc     = perf_exc_q;
`endif

endmodule

// File: tb/tb_wb_retire_queue.sv
// Bench for wb_retire_queue with a scoreboard.
// The driver advances a queue-level reference model and pushes the expected retire events.
// A negedge monitor pops each expected event and compares it whenever the DUT retires something.
`timescale 1ns/1ps
module tb_wb_retire_queue;
    import wb_pkg::*;

    localparam int XLEN    = 32;
    localparam int DEPTH   = 2;
    localparam int NUM_FWD = 2;

    logic                    clk = 1'b0;
    logic                    resetn = 1'b0;
    logic                    mem_to_wb_valid;
    logic [WB_BUS_W-1:0]     mem_to_wb_bus;
    logic                    wb_allowin, csr_ready, csr_re, csr_we;
    logic [13:0]             csr_num;
    logic [XLEN-1:0]         csr_wmask, csr_wvalue, csr_rvalue;
    logic                    wb_ex, ertn_flush, rf_we;
    logic [5:0]              wb_ecode;
    logic [8:0]              wb_esubcode;
    logic [XLEN-1:0]         wb_ex_pc, wb_vaddr, rf_wdata;
    logic [4:0]              rf_waddr;
    logic [NUM_FWD*5-1:0]    fwd_raddr;
    logic [NUM_FWD-1:0]      fwd_hit, fwd_stall;
    logic [NUM_FWD*XLEN-1:0] fwd_data;
    logic [XLEN-1:0]         debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]              debug_wb_rf_we;
    logic [4:0]              debug_wb_rf_wnum;
`ifdef WB_PERF_CNT_EN
    logic [63:0]             perf_retired;
    logic [31:0]             perf_exc;
    longint                  exp_retired = 0;
    int                      exp_exc = 0;
`endif

    always #5 clk = ~clk;

    wb_retire_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_FWD(NUM_FWD)) dut (
        .clk(clk), .resetn(resetn),
        .mem_to_wb_valid(mem_to_wb_valid), .mem_to_wb_bus(mem_to_wb_bus),
        .wb_allowin(wb_allowin), .csr_ready(csr_ready),
        .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_ex_pc(wb_ex_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_stall(fwd_stall), .fwd_data(fwd_data),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`ifdef WB_PERF_CNT_EN
        , .perf_retired(perf_retired), .perf_exc(perf_exc)
`endif
    );

    // Expected retire event. flags = {rf_we, wb_ex, ertn_flush}.
    typedef struct {
        logic [2:0]  flags;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] vaddr;
    } ev_t;

    int        tests = 0;
    int        fails = 0;
    ev_t       exp_q[$];
    wb_entry_t mq[$];      // reference queue contents, oldest first
    bit        dead = 0;   // reference is in the cycle that follows a flush

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic wb_entry_t mk(input bit we, input logic [4:0] a, input logic [31:0] d,
                                     input bit cre, input bit ex, input bit er, input logic [5:0] ec);
        wb_entry_t e;
        e = '0;
        e.rf_we = we; e.rf_waddr = a; e.rf_wdata = d; e.pc = $urandom;
        e.csr_re = cre; e.csr_num = cre ? 14'h5 : 14'h0;
        e.ex_en = ex; e.ertn = er; e.ecode = ec; e.esubcode = 9'($urandom);
        e.vaddr = $urandom;
        return e;
    endfunction

    function automatic wb_entry_t rand_entry();
        wb_entry_t e;
        e.rf_we = ($urandom % 4) != 0;   e.rf_waddr = 5'($urandom % 8);
        e.rf_wdata = $urandom;           e.pc = $urandom;
        e.csr_re = ($urandom % 5) == 0;  e.csr_we = ($urandom % 6) == 0;
        e.csr_num = 14'($urandom);       e.csr_wmask = $urandom;  e.csr_wvalue = $urandom;
        e.ertn = ($urandom % 20) == 0;   e.ex_en = ($urandom % 20) == 0;
        e.ecode = 6'($urandom);          e.esubcode = 9'($urandom); e.vaddr = $urandom;
        return e;
    endfunction

    // One clock cycle: drive the inputs, check the combinational outputs against the model,
    // queue the expected retire event, advance the model and wait for the next edge.
    task automatic cycle(input bit v, input wb_entry_t e, input bit rdy,
                         input logic [31:0] rval, input logic [NUM_FWD*5-1:0] ra);
        wb_entry_t h;
        bit        have, go, allow;
        ev_t       ev;
        mem_to_wb_valid = v; mem_to_wb_bus = e; csr_ready = rdy;
        csr_rvalue = rval;   fwd_raddr = ra;
        #1;
        have = (mq.size() > 0) && !dead;
        h    = (mq.size() > 0) ? mq[0] : '0;
        go   = have && (!(h.csr_re || h.csr_we) || rdy);
        allow = !dead && ((mq.size() < DEPTH) || go);
        chk("allowin", wb_allowin, allow);
        chk("csr_we", csr_we, have && h.csr_we && !h.ex_en && !h.ertn);
        chk("csr_re", csr_re, (have && h.csr_re) || (go && h.ex_en));
        for (int p = 0; p < NUM_FWD; p++) begin
            logic [4:0]  a;
            bit          f, fc;
            logic [31:0] fd;
            a = ra[p*5 +: 5]; f = 0; fc = 0; fd = 0;
            for (int k = mq.size() - 1; k >= 0; k--) begin
                if (!f && a != 0 && mq[k].rf_we && !mq[k].ex_en && mq[k].rf_waddr == a) begin
                    f = 1; fc = mq[k].csr_re; fd = mq[k].rf_wdata;
                end
            end
            chk($sformatf("fwd_hit%0d", p),   fwd_hit[p],   f && !fc);
            chk($sformatf("fwd_stall%0d", p), fwd_stall[p], f && fc);
            chk($sformatf("fwd_data%0d", p),  fwd_data[p*XLEN +: XLEN], (f && !fc) ? fd : 32'h0);
        end
        if (go) begin
            ev.waddr = h.rf_waddr; ev.wdata = h.csr_re ? rval : h.rf_wdata; ev.pc = h.pc;
            ev.ecode = h.ecode; ev.esub = h.esubcode; ev.vaddr = h.vaddr;
            if (h.ex_en)      begin ev.flags = 3'b010; exp_q.push_back(ev); end
            else if (h.ertn)  begin ev.flags = 3'b001; exp_q.push_back(ev); end
            else if (h.rf_we) begin ev.flags = 3'b100; exp_q.push_back(ev); end
`ifdef WB_PERF_CNT_EN
            if (h.ex_en) exp_exc++; else exp_retired++;
`endif
        end
        if (dead) dead = 0;
        else if (go && (h.ex_en || h.ertn)) begin mq.delete(); dead = 1; end
        else begin
            if (go) void'(mq.pop_front());
            if (v && allow) mq.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit rdy, input logic [NUM_FWD*5-1:0] ra);
        cycle(0, '0, rdy, $urandom, ra);
    endtask

    // Assert reset mid-cycle. The queue must empty and all strobes must drop at once, before any clock edge.
    task automatic reset_mid();
        resetn = 0;
        #1;
        chk("rst_allowin", wb_allowin, 1);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_csr_re", csr_re, 0);
        chk("rst_csr_we", csr_we, 0);
        chk("rst_fwd_stall", fwd_stall, 0);
        chk("rst_pulses", {wb_ex, ertn_flush}, 0);
`ifdef WB_PERF_CNT_EN
        chk("rst_perf_retired", perf_retired, 0);
        chk("rst_perf_exc", perf_exc, 0);
        exp_retired = 0; exp_exc = 0;
`endif
        mq.delete(); dead = 0; exp_q.delete();
        @(posedge clk); #1;
        resetn = 1;
    endtask

    // Monitor: whenever the DUT retires something, compare it with the next expected event.
    always @(negedge clk) begin
        ev_t ev;
        if (resetn) begin
            if (rf_we || wb_ex || ertn_flush) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_retire: got rf_we=%0b wb_ex=%0b ertn=%0b, expected none",
                             rf_we, wb_ex, ertn_flush);
                end else begin
                    ev = exp_q.pop_front();
                    chk("retire_kind", {rf_we, wb_ex, ertn_flush}, ev.flags);
                    if (ev.flags == 3'b100) begin
                        chk("rf_waddr", rf_waddr, ev.waddr);
                        chk("rf_wdata", rf_wdata, ev.wdata);
                        chk("dbg_rf_we", debug_wb_rf_we, 4'hf);
                        chk("dbg_wnum", debug_wb_rf_wnum, ev.waddr);
                        chk("dbg_wdata", debug_wb_rf_wdata, ev.wdata);
                        chk("dbg_pc", debug_wb_pc, ev.pc);
                    end else if (ev.flags == 3'b010) begin
                        chk("ex_csr_num", csr_num, CSR_EENTRY);
                        chk("ex_csr_re", csr_re, 1);
                        chk("ex_ecode", wb_ecode, ev.ecode);
                        chk("ex_esub", wb_esubcode, ev.esub);
                        chk("ex_pc", wb_ex_pc, ev.pc);
                        chk("ex_vaddr", wb_vaddr, ev.vaddr);
                        chk("ex_dbg_rf_we", debug_wb_rf_we, 0);
                    end else begin
                        chk("ertn_csr_we", csr_we, 0);
                        chk("ertn_dbg_rf_we", debug_wb_rf_we, 0);
                    end
                end
            end else if (exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                tests++; fails++;
                $display("FAIL missing_retire: got no retire, expected flags %03b", ev.flags);
            end
        end
    end

    initial begin
        mem_to_wb_valid = 0; mem_to_wb_bus = '0; csr_ready = 1;
        csr_rvalue = '0; fwd_raddr = '0;
        #3;
        chk("reset_allowin", wb_allowin, 1);
        chk("reset_strobes", {rf_we, wb_ex, ertn_flush, csr_re, csr_we}, 0);
        chk("reset_data", {csr_num, rf_waddr, rf_wdata, debug_wb_pc}, 0);
        chk("reset_fwd", {fwd_hit, fwd_stall}, 0);
        @(posedge clk); #1;
        resetn = 1;

        // Single ALU op into an empty queue: it retires in the next cycle.
        cycle(1, mk(1, 5'd5, 32'h1234, 0, 0, 0, 0), 1, 0, {5'd0, 5'd5});
        idle(1, {5'd0, 5'd5});
        idle(1, 0);

        // A stalled CSR read fills the queue. The third push is refused, then the queue drains in order.
        cycle(1, mk(1, 5'd3, 32'h0, 1, 0, 0, 0), 0, 32'hc0de, {5'd3, 5'd0});
        cycle(1, mk(1, 5'd1, 32'h11, 0, 0, 0, 0), 0, 32'hc0de, {5'd3, 5'd1});
        cycle(1, mk(1, 5'd2, 32'h22, 0, 0, 0, 0), 0, 32'hc0de, {5'd3, 5'd1});
        cycle(1, mk(1, 5'd2, 32'h22, 0, 0, 0, 0), 1, 32'hbeef, {5'd2, 5'd1});
        idle(1, {5'd2, 5'd1});
        idle(1, 0);

        // Forward from the youngest r7, then stall on a CSR read that targets r7.
        cycle(1, mk(1, 5'd7, 32'h1, 0, 0, 0, 0), 1, 0, {5'd7, 5'd7});
        cycle(1, mk(1, 5'd7, 32'h2, 0, 0, 0, 0), 1, 0, {5'd7, 5'd0});
        idle(1, {5'd7, 5'd7});
        cycle(1, mk(1, 5'd7, 32'h0, 1, 0, 0, 0), 0, 32'h77, {5'd7, 5'd0});
        idle(0, {5'd7, 5'd0});
        idle(1, {5'd7, 5'd0});

        // SYSCALL at the head with one entry behind it. The push made during the flush is dropped.
        cycle(1, mk(1, 5'd1, 32'h0, 1, 0, 0, 0), 0, 32'h5, 0);
        cycle(1, mk(0, 5'd0, 32'h0, 0, 1, 0, ECODE_SYS), 0, 0, 0);
        cycle(1, mk(1, 5'd9, 32'h99, 0, 0, 0, 0), 1, 32'h6, {5'd9, 5'd0});
        cycle(1, mk(1, 5'd10, 32'haa, 0, 0, 0, 0), 1, 0, {5'd9, 5'd10});
        idle(1, {5'd9, 5'd10});
        idle(1, {5'd9, 5'd10});

        // ertn at the head: one flush pulse, then one cycle with allowin low.
        cycle(1, mk(0, 5'd0, 32'h0, 0, 0, 1, 0), 1, 0, 0);
        cycle(1, mk(1, 5'd4, 32'h44, 0, 0, 0, 0), 1, 0, 0);
        cycle(1, mk(1, 5'd4, 32'h44, 0, 0, 0, 0), 1, 0, 0);
        idle(1, 0);
        idle(1, 0);

        // Random traffic.
        for (int i = 0; i < 1500; i++)
            cycle(($urandom % 4) != 0, rand_entry(), ($urandom % 3) != 0, $urandom,
                  NUM_FWD*5'($urandom));

        // Reset while the queue is full and the head is stalled.
        cycle(1, mk(1, 5'd2, 32'h0, 1, 0, 0, 0), 0, 0, 0);
        cycle(1, mk(1, 5'd6, 32'h66, 0, 0, 0, 0), 0, 0, {5'd6, 5'd2});
        idle(0, {5'd6, 5'd2});
        reset_mid();
        for (int i = 0; i < 40; i++)
            cycle(($urandom % 2) != 0, rand_entry(), 1, $urandom, NUM_FWD*5'($urandom));
        idle(1, 0);
        idle(1, 0);
`ifdef WB_PERF_CNT_EN
        chk("perf_retired", perf_retired, exp_retired);
        chk("perf_exc", perf_exc, exp_exc);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
